// File: rtl/osc_meas_pkg.sv
// Shared types for the ring-oscillator measurement sequencer: FSM states,
// mode encodings, oscillator select values and the oscillator choice rule.
package osc_meas_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        GATE,
        CAPTURE,
        HOLD
    } meas_state_t;

    localparam logic [1:0] MODE_INV  = 2'b00;
    localparam logic [1:0] MODE_NAND = 2'b01;
    localparam logic [1:0] MODE_ALT  = 2'b10;

    localparam logic OSC_INV  = 1'b0;
    localparam logic OSC_NAND = 1'b1;

    // Mode 11 falls through to the inverter ring, same as mode 00.
    function automatic logic choose_osc(input logic [1:0] mode, input logic phase);
        case (mode)
            MODE_NAND: return OSC_NAND;
            MODE_ALT:  return phase;
            default:   return OSC_INV;
        endcase
    endfunction

endpackage

// File: rtl/osc_meas_sequencer_timer.sv
// Loadable down-counter used for the settle, gate and drop intervals.
// done is high while the remaining count is zero.
module interval_timer #(
    parameter int TMR_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             done
);

    logic [TMR_W-1:0] remaining;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= load_val;
        end else if (remaining != '0) begin
            remaining <= remaining - TMR_W'(1);
        end
    end

    assign done = (remaining == '0);

endmodule

// File: rtl/osc_meas_sequencer.sv
// Ring-oscillator measurement sequencer: settle, gate, capture, hand off.
// Define MEAS_DROP_EN to discard results that sit unaccepted for DROP_CYCLES.
module osc_meas_sequencer
    import osc_meas_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int WIN_CYCLES    = 1000,
    parameter int SETTLE_CYCLES = 16,
    parameter int TMR_W         = 16
`ifdef MEAS_DROP_EN
    ,
    parameter int DROP_CYCLES   = 4096
`endif
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             run,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] count,
    output logic             en_inv_osc,
    output logic             en_nand_osc,
    output logic             osc_sel,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic [CNT_W-1:0] meas_data,
    output logic             meas_src,
    output logic             meas_sat,
    output logic             meas_valid,
`ifdef MEAS_DROP_EN
    output logic             meas_drop,
`endif
    input  logic             meas_ready,
    output logic             busy
);

    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] WIN_LD    = TMR_W'(WIN_CYCLES - 1);
`ifdef MEAS_DROP_EN
    localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(DROP_CYCLES - 1);
`else
    localparam logic [TMR_W-1:0] HOLD_LD   = '0;
`endif

    meas_state_t      state;
    logic [1:0]       mode_q;
    logic             phase;
    logic             xfer;
    logic             drop_now;
    logic             hold_exit;
    logic             next_phase;
    logic             start_sel;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;

    assign xfer = meas_valid & meas_ready;

`ifdef MEAS_DROP_EN
    assign drop_now = (state == HOLD) & tmr_done & ~xfer;
`else
    assign drop_now = 1'b0;
`endif

    assign hold_exit  = (state == HOLD) & (xfer | drop_now);
    assign next_phase = (hold_exit && mode_q == MODE_ALT) ? ~phase : phase;
    assign start_sel  = choose_osc(mode, next_phase);

    // Reload on every state entry; the loaded value is the length of the state being entered.
    assign tmr_load = tmr_done | (state == IDLE) | (state == CAPTURE) | hold_exit;

    always_comb begin
        tmr_val = SETTLE_LD;
        case (state)
            SETTLE:  tmr_val = WIN_LD;
            CAPTURE: tmr_val = HOLD_LD;
            default: tmr_val = SETTLE_LD;
        endcase
    end

    interval_timer #(
        .TMR_W(TMR_W)
    ) u_timer (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state       <= IDLE;
            mode_q      <= MODE_INV;
            phase       <= OSC_INV;
            en_inv_osc  <= 1'b0;
            en_nand_osc <= 1'b0;
            osc_sel     <= OSC_INV;
            cnt_clr     <= 1'b0;
            cnt_en      <= 1'b0;
            meas_data   <= '0;
            meas_src    <= 1'b0;
            meas_sat    <= 1'b0;
            meas_valid  <= 1'b0;
            busy        <= 1'b0;
`ifdef MEAS_DROP_EN
            meas_drop   <= 1'b0;
`endif
        end else begin
            cnt_clr <= 1'b0;
            cnt_en  <= 1'b0;
`ifdef MEAS_DROP_EN
            meas_drop <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (run) begin
                        state       <= SETTLE;
                        mode_q      <= mode;
                        osc_sel     <= start_sel;
                        en_inv_osc  <= (start_sel == OSC_INV);
                        en_nand_osc <= (start_sel == OSC_NAND);
                        cnt_clr     <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (!run) begin
                        state       <= IDLE;
                        en_inv_osc  <= 1'b0;
                        en_nand_osc <= 1'b0;
                        busy        <= 1'b0;
                    end else if (tmr_done) begin
                        state  <= GATE;
                        cnt_en <= 1'b1;
                    end else begin
                        cnt_clr <= 1'b1;
                    end
                end
                GATE: begin
                    if (!run) begin
                        state       <= IDLE;
                        en_inv_osc  <= 1'b0;
                        en_nand_osc <= 1'b0;
                        busy        <= 1'b0;
                    end else if (tmr_done) begin
                        state <= CAPTURE;
                    end else begin
                        cnt_en <= 1'b1;
                    end
                end
                // The gate closed a cycle ago, so count is stable here.
                CAPTURE: begin
                    state       <= HOLD;
                    meas_data   <= count;
                    meas_src    <= osc_sel;
                    meas_sat    <= &count;
                    meas_valid  <= 1'b1;
                    en_inv_osc  <= 1'b0;
                    en_nand_osc <= 1'b0;
                end
                HOLD: begin
                    if (hold_exit) begin
                        meas_valid <= 1'b0;
                        phase      <= next_phase;
`ifdef MEAS_DROP_EN
                        meas_drop  <= drop_now;
`endif
                        if (run) begin
                            state       <= SETTLE;
                            mode_q      <= mode;
                            osc_sel     <= start_sel;
                            en_inv_osc  <= (start_sel == OSC_INV);
                            en_nand_osc <= (start_sel == OSC_NAND);
                            cnt_clr     <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
